// File: rtl/usr_cmd_sequencer.sv
// Command sequencer for the 4-bit universal shift register: runs one op for N cycles, pulses done,
// and keeps a shadow copy of the register contents.
module usr_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] par_out,
  output logic             il,
  output logic             ir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shadow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  state_t           state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic             running;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_q   <= OP_HOLD;
      cnt_q  <= '0;
      data_q <= '0;
      fill_q <= 1'b0;
      shadow <= '0;
      done   <= 1'b0;
    end else if (flush) begin
      // Abort without a done pulse; shadow keeps whatever the register already holds.
      state <= IDLE;
      cnt_q <= '0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            fill_q <= cmd_fill;
            if (cmd_op == OP_LOAD || cmd_count == '0)
              cnt_q <= CNT_W'(1);
            else
              cnt_q <= cmd_count;
            state <= RUN;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          unique case (op_q)
            OP_HOLD: shadow <= shadow;
            OP_SHR:  shadow <= {fill_q, shadow[WIDTH-1:1]};
            OP_SHL:  shadow <= {shadow[WIDTH-2:0], fill_q};
            OP_LOAD: shadow <= data_q;
          endcase
          if (cnt_q <= CNT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Register-facing outputs decode only registered state; flush alone may force hold.
  assign running   = (state == RUN);
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE) && !flush;
  assign sel       = (running && !flush) ? op_q : OP_HOLD;
  assign par_out   = running ? data_q : '0;
  assign ir        = running && (op_q == OP_SHR) && fill_q;
  assign il        = running && (op_q == OP_SHL) && fill_q;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Directed self-checking bench for usr_cmd_sequencer: load, shifts, count=0, flush and async reset.
module tb_usr_cmd_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_fill = 1'b0;
  logic [1:0]       sel;
  logic [WIDTH-1:0] par_out;
  logic             il;
  logic             ir;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shadow;

  int n_checks = 0;
  int n_fail   = 0;

  usr_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .sel(sel), .par_out(par_out), .il(il), .ir(ir),
    .busy(busy), .done(done), .shadow(shadow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                       input logic [WIDTH-1:0] data, input logic fill);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    cmd_fill  = fill;
  endtask

  initial begin
    // Reset
    #22 rst = 1'b1;
    tick();
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_shadow", 32'(shadow), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h1);
    check("rst_done", 32'(done), 32'h0);

    // Parallel load, count 5 forced to 1
    issue(2'b11, 3'd5, 4'b1010, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("ld_sel", 32'(sel), 32'h3);
    check("ld_par", 32'(par_out), 32'hA);
    check("ld_ready", 32'(cmd_ready), 32'h0);
    tick();
    check("ld_sel_end", 32'(sel), 32'h0);
    check("ld_done", 32'(done), 32'h1);
    check("ld_shadow", 32'(shadow), 32'hA);
    tick();
    check("ld_done_clr", 32'(done), 32'h0);
    check("ld_ready_back", 32'(cmd_ready), 32'h1);

    // Shift right, fill 1, count 3
    issue(2'b01, 3'd3, 4'b0000, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("shr_sel1", 32'(sel), 32'h1);
    check("shr_ir", 32'(ir), 32'h1);
    check("shr_il", 32'(il), 32'h0);
    tick();
    check("shr_sh1", 32'(shadow), 32'hD);
    check("shr_sel2", 32'(sel), 32'h1);
    check("shr_done_early", 32'(done), 32'h0);
    tick();
    check("shr_sh2", 32'(shadow), 32'hE);
    check("shr_sel3", 32'(sel), 32'h1);
    tick();
    check("shr_sh3", 32'(shadow), 32'hF);
    check("shr_done", 32'(done), 32'h1);
    check("shr_sel_end", 32'(sel), 32'h0);
    check("shr_ir_end", 32'(ir), 32'h0);
    tick();
    check("shr_done_clr", 32'(done), 32'h0);

    // Shift left, fill 0, count 0 treated as 1
    issue(2'b10, 3'd0, 4'b0000, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("shl_sel", 32'(sel), 32'h2);
    check("shl_il", 32'(il), 32'h0);
    tick();
    check("shl_shadow", 32'(shadow), 32'hE);
    check("shl_done", 32'(done), 32'h1);
    check("shl_sel_end", 32'(sel), 32'h0);
    tick();

    // Shift right count 7, second command held off, flush in 3rd RUN cycle
    issue(2'b01, 3'd7, 4'b0000, 1'b0);
    tick();
    check("fl_sel1", 32'(sel), 32'h1);
    check("fl_ready1", 32'(cmd_ready), 32'h0);
    issue(2'b11, 3'd1, 4'b0101, 1'b1);
    tick();
    check("fl_sh1", 32'(shadow), 32'h7);
    check("fl_ready2", 32'(cmd_ready), 32'h0);
    tick();
    check("fl_sh2", 32'(shadow), 32'h3);
    check("fl_sel3", 32'(sel), 32'h1);
    flush = 1'b1;
    #1;
    check("fl_sel_forced", 32'(sel), 32'h0);
    check("fl_ready_flush", 32'(cmd_ready), 32'h0);
    tick();
    flush = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("fl_busy", 32'(busy), 32'h0);
    check("fl_no_done", 32'(done), 32'h0);
    check("fl_shadow", 32'(shadow), 32'h3);
    check("fl_ready_back", 32'(cmd_ready), 32'h1);
    check("fl_par", 32'(par_out), 32'h0);
    tick();
    check("fl_still_idle", 32'(busy), 32'h0);

    // Async reset mid-RUN
    issue(2'b10, 3'd4, 4'b0000, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("ar_il", 32'(il), 32'h1);
    tick();
    check("ar_sh1", 32'(shadow), 32'h7);
    #2 rst = 1'b0;
    #1;
    check("ar_sel", 32'(sel), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_shadow", 32'(shadow), 32'h0);
    check("ar_il_clr", 32'(il), 32'h0);
    check("ar_done", 32'(done), 32'h0);
    #4 rst = 1'b1;
    tick();
    check("ar_idle_after", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
